// File: rtl/txmux_pkg.sv
// Shared types and constants for the multi-channel TX buffer/arbiter.
// MULTI_CHAN_TX_MUX_TAG_EN adds the TAG state and the tag prefix constant.
package txmux_pkg;

    typedef enum logic {
        SINGLE      = 1'b0,
        ROUND_ROBIN = 1'b1
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
`ifdef MULTI_CHAN_TX_MUX_TAG_EN
        TAG,
`endif
        LOAD,
        HOLD
    } state_t;

`ifdef MULTI_CHAN_TX_MUX_TAG_EN
    localparam logic [3:0] TAG_PREFIX = 4'hA;
`endif

    localparam int DROP_W = 16;

endpackage

// File: rtl/chan_fifo.sv
// Single-channel sample FIFO: inferred dual-port RAM with a registered read port.
// A push into a full FIFO is refused; a pop from an empty FIFO is ignored.
module chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty come from the pre-cycle count, so a same-cycle pop never admits a push.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/multi_chan_tx_mux.sv
// N-channel sample buffer with a SINGLE / ROUND_ROBIN drain arbiter onto a byte sink.
// MULTI_CHAN_TX_MUX_TAG_EN: in ROUND_ROBIN each sample is preceded by a channel tag byte.
module multi_chan_tx_mux
    import txmux_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CH_W       = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [N_CH*WIDTH-1:0]  wr_data,
    input  logic [CH_W-1:0]        sel,
    input  logic                   mode,
    input  logic                   tx_enable,
    output logic [WIDTH-1:0]       tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [CH_W-1:0]        tx_chan,
    output logic [N_CH-1:0]        empty,
    output logic [N_CH-1:0]        full,
    output logic [ADDR_WIDTH:0]    sel_count,
    output logic [DROP_W-1:0]      drop_count
);

    state_t            state_q;
    mode_t             mode_q;
    logic [CH_W-1:0]   chan_q, rr_ptr_q, tx_chan_q;
    logic [WIDTH-1:0]  tx_data_q;
    logic              tx_valid_q;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [N_CH-1:0]   pop;
    logic [WIDTH-1:0]  rd_data [N_CH];
    logic [ADDR_WIDTH:0] count [N_CH];

    logic              rr_hit, sel_hit, tgt_hit;
    logic [CH_W-1:0]   rr_ch, tgt_ch;
    logic [3:0]        n_drop;
    logic [DROP_W:0]   drop_sum;

    for (genvar c = 0; c < N_CH; c++) begin : g_fifo
        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i     (clk),
            .rst_i     (rst),
            .push_i    (wr_en),
            .pop_i     (pop[c]),
            .wr_data_i (wr_data[c*WIDTH +: WIDTH]),
            .rd_data_o (rd_data[c]),
            .count_o   (count[c]),
            .empty_o   (empty[c]),
            .full_o    (full[c])
        );
    end

    // Round-robin target: first non-empty channel at or after rr_ptr_q, wrapping.
    always_comb begin
        rr_hit = 1'b0;
        rr_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!rr_hit && !empty[(int'(rr_ptr_q) + i) % N_CH]) begin
                rr_hit = 1'b1;
                rr_ch  = CH_W'((int'(rr_ptr_q) + i) % N_CH);
            end
        end
    end

    // An out-of-range sel selects nothing: no fetch and a zero occupancy.
    always_comb begin
        sel_hit   = 1'b0;
        sel_count = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (CH_W'(c) == sel) begin
                sel_hit   = !empty[c];
                sel_count = count[c];
            end
        end
    end

    assign tgt_hit = (mode_t'(mode) == ROUND_ROBIN) ? rr_hit : sel_hit;
    assign tgt_ch  = (mode_t'(mode) == ROUND_ROBIN) ? rr_ch  : sel;

    always_comb begin
        pop = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (state_q == FETCH && CH_W'(c) == chan_q) pop[c] = 1'b1;
        end
    end

    always_comb begin
        n_drop = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (wr_en && full[c]) n_drop = n_drop + 4'd1;
        end
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    // Sink handshake: a byte transfers on a clock edge where tx_valid && tx_ready;
    // while tx_valid is high, tx_data/tx_chan hold and tx_valid stays up until that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= SINGLE;
            chan_q     <= '0;
            rr_ptr_q   <= '0;
            tx_chan_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_enable && tgt_hit) begin
                        chan_q  <= tgt_ch;
                        mode_q  <= mode_t'(mode);
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
`ifdef MULTI_CHAN_TX_MUX_TAG_EN
                    if (mode_q == ROUND_ROBIN) begin
                        tx_data_q  <= WIDTH'({TAG_PREFIX, 1'b0, 3'(chan_q)});
                        tx_chan_q  <= chan_q;
                        tx_valid_q <= 1'b1;
                        state_q    <= TAG;
                    end else begin
                        state_q <= LOAD;
                    end
`else
                    state_q <= LOAD;
`endif
                end
`ifdef MULTI_CHAN_TX_MUX_TAG_EN
                TAG: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
`endif
                LOAD: begin
                    tx_data_q  <= rd_data[chan_q];
                    tx_chan_q  <= chan_q;
                    tx_valid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                        if (mode_q == ROUND_ROBIN) begin
                            rr_ptr_q <= (int'(chan_q) == N_CH - 1) ? '0 : chan_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_chan    = tx_chan_q;
    assign drop_count = drop_q;

endmodule
